// File: rtl/alu_pipe.sv
// alu_pipe: XLEN-wide integer execute unit (RV32I/RV64I base ops plus the
// optional M extension) with a registered result and valid/ready handshakes.
//
// Base ops finish on the acceptance edge, so a result is available the next
// cycle. M ops run iteratively: a shift-add multiply or a restoring divide
// takes one step per cycle for XLEN cycles. A single FIX cycle then applies
// sign correction and the RISC-V special cases.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operation handshake (accepted when both high)
//   alu_immediate_enable     1 = operand B is immediate_data
//   register_read_data_a/b   register operands
//   immediate_data           sign-extended immediate
//   operation                5-bit opcode
//   out_valid / out_ready    result handshake (taken when both high)
//   alu_out                  result
//   illegal_op               result came from an undefined opcode
//   busy                     an M op is iterating
module alu_pipe #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            alu_immediate_enable,
  input  logic [XLEN-1:0] register_read_data_a,
  input  logic [XLEN-1:0] register_read_data_b,
  input  logic [XLEN-1:0] immediate_data,
  input  logic [4:0]      operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            illegal_op,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  LAST_STEP = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  // Sign-correction helpers for the FIX cycle.
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic neg,
                                                     input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Control state (reset)
  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_out_q, alu_out_d;
  logic              illegal_q, illegal_d;

  // Iteration datapath (no reset; only meaningful while an M op runs)
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic              div_ovf_q, div_ovf_d;
  logic [SHW-1:0]    count_q, count_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;

  // Operand selection and acceptance
  logic [XLEN-1:0]   op_a, op_b;
  logic [SHW-1:0]    shamt;
  logic              accept, is_m_op;
  logic              a_sgn, b_sgn, neg_a, neg_b;

  assign op_a    = register_read_data_a;
  assign op_b    = alu_immediate_enable ? immediate_data : register_read_data_b;
  assign shamt   = op_b[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept  = in_valid && in_ready;
  assign is_m_op = ENABLE_M && (operation[4:3] == 2'b10);

  // Which operands of an M op are interpreted as signed.
  assign a_sgn = operation inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn = operation inside {OP_MULH, OP_DIV, OP_REM};
  assign neg_a = a_sgn && op_a[XLEN-1];
  assign neg_b = b_sgn && op_b[XLEN-1];

  // Single-cycle base ops
  logic [XLEN-1:0] base_res;
  logic            base_ill;

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (operation)
      OP_ADD:  base_res = op_a + op_b;
      OP_SUB:  base_res = op_a - op_b;
      OP_SLL:  base_res = op_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  base_res = op_a ^ op_b;
      OP_SRL:  base_res = op_a >> shamt;
      OP_SRA:  base_res = $signed(op_a) >>> shamt;
      OP_OR:   base_res = op_a | op_b;
      OP_AND:  base_res = op_a & op_b;
      default: base_ill = 1'b1;
    endcase
  end

  // One iteration step of each engine
  logic [XLEN-1:0] mul_addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole product right.
  assign mul_addend = prod_q[0] ? a_mag_q : {XLEN{1'b0}};
  assign mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};

  // Restoring divide: bring in the next dividend bit and keep the
  // subtraction only when it did not borrow.
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_mag_q};

  // Final result for the FIX cycle
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   fix_res;

  assign prod_signed = cond_neg_wide(neg_res_q, prod_q);

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)     fix_res = '1;
        else if (div_ovf_q) fix_res = a_raw_q;
        else                fix_res = cond_neg(neg_res_q, quo_q);
      end
      default: begin
        if (div_zero_q)     fix_res = a_raw_q;
        else if (div_ovf_q) fix_res = '0;
        else                fix_res = cond_neg(neg_rem_q, rem_q);
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    illegal_d   = illegal_q;
    op_d        = op_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    a_raw_d     = a_raw_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    div_ovf_d   = div_ovf_q;
    count_d     = count_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    quo_d       = quo_q;

    case (state_q)
      S_IDLE: begin
        // A held result leaves when the consumer takes it; a new base op
        // accepted on the same edge overwrites it immediately.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (is_m_op) begin
            op_d       = operation;
            a_raw_d    = op_a;
            a_mag_d    = cond_neg(neg_a, op_a);
            b_mag_d    = cond_neg(neg_b, op_b);
            neg_res_d  = neg_a ^ neg_b;
            neg_rem_d  = neg_a;
            div_zero_d = (op_b == '0);
            div_ovf_d  = (operation inside {OP_DIV, OP_REM}) &&
                         (op_a == MOST_NEG) && (&op_b);
            count_d    = '0;
            prod_d     = {{XLEN{1'b0}}, b_mag_d};
            rem_d      = '0;
            quo_d      = a_mag_d;
            state_d    = operation[2] ? S_DIV : S_MUL;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = base_ill ? '0 : base_res;
            illegal_d   = base_ill;
          end
        end
      end

      S_MUL: begin
        prod_d  = {mul_sum, prod_q[XLEN-1:1]};
        count_d = count_q + SHW'(1);
        if (count_q == LAST_STEP) state_d = S_FIX;
      end

      S_DIV: begin
        if (!div_diff[XLEN]) begin
          rem_d = div_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = div_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q + SHW'(1);
        if (count_q == LAST_STEP) state_d = S_FIX;
      end

      S_FIX: begin
        alu_out_d   = fix_res;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      illegal_q   <= illegal_d;
    end
  end

  // Iteration datapath registers
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    a_mag_q    <= a_mag_d;
    b_mag_q    <= b_mag_d;
    a_raw_q    <= a_raw_d;
    neg_res_q  <= neg_res_d;
    neg_rem_q  <= neg_rem_d;
    div_zero_q <= div_zero_d;
    div_ovf_q  <= div_ovf_d;
    count_q    <= count_d;
    prod_q     <= prod_d;
    rem_q      <= rem_d;
    quo_q      <= quo_d;
  end

  assign out_valid  = out_valid_q;
  assign alu_out    = alu_out_q;
  assign illegal_op = illegal_q;
  assign busy       = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (XLEN=32). A second instance with ENABLE_M=0
// shares the operand/opcode inputs but has its own handshake signals.
module tb_alu_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic        imm_en;
  logic [31:0] rega, regb, immd;
  logic [4:0]  operation;
  logic        out_valid, out_ready;
  logic [31:0] alu_out;
  logic        illegal_op, busy;

  logic        in_valid1, in_ready1, out_valid1, illegal1, busy1;
  logic        out_ready1;
  logic [31:0] alu_out1;

  alu_pipe #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_immediate_enable(imm_en), .register_read_data_a(rega),
    .register_read_data_b(regb), .immediate_data(immd), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .illegal_op(illegal_op), .busy(busy)
  );

  alu_pipe #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_immediate_enable(imm_en), .register_read_data_a(rega),
    .register_read_data_b(regb), .immediate_data(immd), .operation(operation),
    .out_valid(out_valid1), .out_ready(out_ready1), .alu_out(alu_out1),
    .illegal_op(illegal1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ie;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: RISC-V semantics in plain integer arithmetic.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input bit m_en);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    if (op >= 5'd16 && op <= 5'd23 && !m_en) return {1'b1, 32'h0};
    case (op)
      5'd0:  return {1'b0, a + b};
      5'd1:  return {1'b0, a - b};
      5'd2:  return {1'b0, a << b[4:0]};
      5'd3:  return {1'b0, 31'b0, (sa < sb)};
      5'd4:  return {1'b0, 31'b0, (a < b)};
      5'd5:  return {1'b0, a ^ b};
      5'd6:  return {1'b0, a >> b[4:0]};
      5'd7:  return {1'b0, 32'(sa >>> b[4:0])};
      5'd8:  return {1'b0, a | b};
      5'd9:  return {1'b0, a & b};
      5'd16: return {1'b0, a * b};
      5'd17: begin ps = longint'(sa) * longint'(sb); return {1'b0, ps[63:32]}; end
      5'd18: begin ps = longint'(sa) * longint'({32'b0, b}); return {1'b0, ps[63:32]}; end
      5'd19: begin pu = {32'b0, a} * {32'b0, b}; return {1'b0, pu[63:32]}; end
      5'd20: begin
        if (b == 0) return {1'b0, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, a};
        return {1'b0, 32'(sa / sb)};
      end
      5'd21: begin
        if (b == 0) return {1'b0, 32'hFFFFFFFF};
        return {1'b0, a / b};
      end
      5'd22: begin
        if (b == 0) return {1'b0, a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0};
        return {1'b0, 32'(sa % sb)};
      end
      5'd23: begin
        if (b == 0) return {1'b0, a};
        return {1'b0, a % b};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Offer an op to the main DUT and return at the sample after its acceptance edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ie, input logic [31:0] imm);
    int n;
    n = 0;
    in_valid = 1'b1; operation = op; rega = a; regb = b; imm_en = ie; immd = imm;
    #1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready=%0d required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    operation = 5'($urandom); rega = $urandom; regb = $urandom;
    immd = $urandom; imm_en = 1'($urandom);
  endtask

  // Issue with out_ready=1 and wait (bounded) for the result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ie, input logic [31:0] imm,
                        output logic [31:0] res, output logic ill, output int lat,
                        output logic saw_ready);
    out_ready = 1'b1;
    issue(op, a, b, ie, imm);
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_ready = 1'b1;
      step();
      lat++;
    end
    if (!out_valid) lat = 999;
    res = alu_out;
    ill = illegal_op;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] res;
  logic        ill, saw_ready, flag;
  int          lat;
  logic [4:0]  valid_ops [18];

  initial begin
    valid_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                  5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

    vecs.push_back('{5'd0,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h0,        32'h80000000, 1'b0});
    vecs.push_back('{5'd1,  32'h00000000, 32'h00000001, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{5'd7,  32'h80000000, 32'h0000001F, 1'b1, 32'h00000024, 32'hF8000000, 1'b0});
    vecs.push_back('{5'd4,  32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000001, 1'b0});
    vecs.push_back('{5'd3,  32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{5'd2,  32'h00000001, 32'h0000003F, 1'b0, 32'h0,        32'h80000000, 1'b0});
    vecs.push_back('{5'd6,  32'h80000000, 32'h00000021, 1'b0, 32'h0,        32'h40000000, 1'b0});
    vecs.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'h0FF00FF0, 1'b0});
    vecs.push_back('{5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'hFFF0FFF0, 1'b0});
    vecs.push_back('{5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0,        32'hF000F000, 1'b0});
    vecs.push_back('{5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000001, 1'b0});
    vecs.push_back('{5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{5'd20, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80000000, 1'b0});
    vecs.push_back('{5'd22, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{5'd21, 32'h00000007, 32'h00000000, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{5'd23, 32'h00000007, 32'h00000000, 1'b0, 32'h0,        32'h00000007, 1'b0});
    vecs.push_back('{5'd20, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h0,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{5'd22, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{5'd20, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{5'd22, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'h0,        32'hFFFFFFF9, 1'b0});
    vecs.push_back('{5'd31, 32'h00000005, 32'h00000006, 1'b0, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{5'd12, 32'h00000005, 32'h00000006, 1'b0, 32'h0,        32'h00000000, 1'b1});

    rst = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b1;
    imm_en = 1'b0; rega = '0; regb = '0; immd = '0; operation = '0;
    repeat (3) step();
    check("reset_out_valid", out_valid, 0);
    check("reset_alu_out", alu_out, 0);
    check("reset_illegal", illegal_op, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    step();
    check("reset_in_ready", in_ready, 1);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ie, vecs[i].imm, res, ill, lat, saw_ready);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp);
      check($sformatf("vec%0d_ill", i), ill, vecs[i].exp_ill);
      if (vecs[i].op >= 5'd16 && vecs[i].op <= 5'd23) begin
        check($sformatf("vec%0d_latency", i), lat, 34);
        check($sformatf("vec%0d_in_ready_low", i), saw_ready, 0);
      end else begin
        check($sformatf("vec%0d_latency", i), lat, 1);
      end
    end

    // Base-op result held under backpressure, then drain + accept on one edge
    out_ready = 1'b1; step(); step();
    out_ready = 1'b0;
    issue(5'd0, 32'd2, 32'd3, 1'b0, 32'h0);
    check("stall_first_valid", out_valid, 1);
    check("stall_first_res", alu_out, 32'd5);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_res", k), alu_out, 32'd5);
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
    end
    in_valid = 1'b1; operation = 5'd1; rega = 32'd10; regb = 32'd4; imm_en = 1'b0;
    out_ready = 1'b1;
    #1;
    check("drain_accept_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("drain_accept_valid", out_valid, 1);
    check("drain_accept_res", alu_out, 32'd6);
    step();
    check("drain_done_valid", out_valid, 0);

    // M result held in DONE under backpressure
    out_ready = 1'b0;
    issue(5'd16, 32'd3, 32'd5, 1'b0, 32'h0);
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    check("mstall_latency", lat, 34);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mstall%0d_valid", k), out_valid, 1);
      check($sformatf("mstall%0d_res", k), alu_out, 32'd15);
      check($sformatf("mstall%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("mstall_release_valid", out_valid, 0);
    check("mstall_release_in_ready", in_ready, 1);

    // Back-to-back base ops: one result per cycle
    out_ready = 1'b1;
    in_valid = 1'b1; imm_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      operation = 5'd0; rega = 32'(k * 10); regb = 32'(k);
      #1;
      check($sformatf("b2b%0d_in_ready", k), in_ready, 1);
      step();
      check($sformatf("b2b%0d_valid", k), out_valid, 1);
      check($sformatf("b2b%0d_res", k), alu_out, 32'(k * 11));
    end
    in_valid = 1'b0;
    step();

    // Reset aborts an in-flight DIV
    issue(5'd20, 32'd100, 32'd7, 1'b0, 32'h0);
    repeat (9) step();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    step();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    rst = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) flag = 1'b1;
    end
    check("abort_no_stale_result", flag, 0);
    run_op(5'd31, 32'h1234, 32'h5678, 1'b0, 32'h0, res, ill, lat, saw_ready);
    check("post_abort_illegal", ill, 1);
    check("post_abort_res", res, 0);

    // ENABLE_M=0 instance: base op works, M opcode is illegal
    step(); step();
    operation = 5'd0; rega = 32'd3; regb = 32'd4; imm_en = 1'b0; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check("nom_add_valid", out_valid1, 1);
    check("nom_add_res", alu_out1, 32'd7);
    check("nom_add_illegal", illegal1, 0);
    operation = 5'd16; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check("nom_mul_valid", out_valid1, 1);
    check("nom_mul_illegal", illegal1, 1);
    check("nom_mul_res", alu_out1, 0);
    check("nom_mul_busy", busy1, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b, imm, beff;
      logic        ie;
      logic [32:0] exp;
      if ($urandom_range(0, 9) < 8) op = valid_ops[$urandom_range(0, 17)];
      else op = 5'($urandom_range(0, 31));
      a = pick_operand();
      b = pick_operand();
      imm = pick_operand();
      ie = 1'($urandom_range(0, 1));
      beff = ie ? imm : b;
      exp = ref_alu(op, a, beff, 1'b1);
      run_op(op, a, b, ie, imm, res, ill, lat, saw_ready);
      check($sformatf("rnd%0d_op%0d_res", i, op), res, exp[31:0]);
      check($sformatf("rnd%0d_op%0d_ill", i, op), ill, exp[32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
